transaccion_cajero: RTL and testbench

Transaction stage of the automatic cashier, directly downstream of the PIN-entry stage. Starts when the PIN stage reports a verified PIN, loads the account balance, accepts a transaction type (deposit/withdrawal) and a decimal amount keyed digit by digit, then updates the balance or rejects the withdrawal for insufficient funds. Reports completion with a one-cycle `fin` pulse and returns to idle for the next card.

---
 rtl/transaccion_cajero.sv | 138 +++++++++++++
 tb/tb_transaccion_cajero.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/transaccion_cajero.sv
// Cashier transaction stage: balance load, type select, keyed amount,
// deposit/withdrawal execution with one-cycle result pulses.
module transaccion_cajero #(
  parameter int BAL_W   = 64,
  parameter int MONTO_W = 32,
  parameter int MAX_DIG = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pin_ok,
  input  logic [BAL_W-1:0]   balance_in,
  input  logic               tipo_stb,
  input  logic               tipo_trans,
  input  logic               digito_stb,
  input  logic [3:0]         digito,
  input  logic               enter_stb,
  input  logic               cancelar,
  output logic [BAL_W-1:0]   balance_out,
  output logic               balance_actualizar,
  output logic               entregar_dinero,
  output logic               fondos_insuficientes,
  output logic [MONTO_W-1:0] monto,
  output logic               ocupado,
  output logic               fin
);

  localparam int CNT_W = $clog2(MAX_DIG + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEL_TIPO = 3'd1;
  localparam logic [2:0] MONTO    = 3'd2;
  localparam logic [2:0] EJECUTAR = 3'd3;
  localparam logic [2:0] FIN      = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic             tipo_q;
  logic [CNT_W-1:0] n_dig;
  logic [BAL_W-1:0] monto_ext;
  logic [BAL_W:0]   suma;
  logic             dig_ok;

  assign monto_ext = BAL_W'(monto);
  assign suma      = {1'b0, balance_out} + {1'b0, monto_ext};
  assign dig_ok    = digito_stb && (digito <= 4'd9)
                  && (n_dig < CNT_W'(MAX_DIG));

  // Next-state selection; cancel wins in every interruptible state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pin_ok) state_next = SEL_TIPO;
      end
      SEL_TIPO: begin
        if (cancelar)      state_next = IDLE;
        else if (tipo_stb) state_next = MONTO;
      end
      MONTO: begin
        if (cancelar)       state_next = IDLE;
        else if (enter_stb) state_next = EJECUTAR;
      end
      EJECUTAR: begin
        if (cancelar) state_next = IDLE;
        else          state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ocupado <= 1'b0;
    end else begin
      state   <= state_next;
      ocupado <= (state_next != IDLE);
    end
  end

  // Balance, amount entry and one-cycle result pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      balance_out          <= '0;
      monto                <= '0;
      n_dig                <= '0;
      tipo_q               <= 1'b0;
      balance_actualizar   <= 1'b0;
      entregar_dinero      <= 1'b0;
      fondos_insuficientes <= 1'b0;
      fin                  <= 1'b0;
    end else begin
      balance_actualizar   <= 1'b0;
      entregar_dinero      <= 1'b0;
      fondos_insuficientes <= 1'b0;
      fin                  <= 1'b0;
      case (state)
        IDLE: begin
          if (pin_ok) begin
            balance_out <= balance_in;
            monto       <= '0;
            n_dig       <= '0;
          end
        end
        SEL_TIPO: begin
          if (!cancelar && tipo_stb) tipo_q <= tipo_trans;
        end
        MONTO: begin
          if (!cancelar && !enter_stb && dig_ok) begin
            monto <= monto * MONTO_W'(10) + MONTO_W'(digito);
            n_dig <= n_dig + CNT_W'(1);
          end
        end
        EJECUTAR: begin
          if (!cancelar) begin
            fin <= 1'b1;
            if (monto != '0) begin
              if (!tipo_q) begin
                balance_out <= suma[BAL_W] ? '1 : suma[BAL_W-1:0];
                balance_actualizar <= 1'b1;
              end else if (monto_ext <= balance_out) begin
                balance_out        <= balance_out - monto_ext;
                balance_actualizar <= 1'b1;
                entregar_dinero    <= 1'b1;
              end else begin
                fondos_insuficientes <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_transaccion_cajero.sv
// Directed bench for transaccion_cajero with a per-cycle reference model
// and hand-computed literal checks.
module tb_transaccion_cajero;

  localparam int BAL_W   = 64;
  localparam int MONTO_W = 32;
  localparam logic [BAL_W-1:0] MAXB = {BAL_W{1'b1}};

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               pin_ok = 1'b0;
  logic [BAL_W-1:0]   balance_in = '0;
  logic               tipo_stb = 1'b0;
  logic               tipo_trans = 1'b0;
  logic               digito_stb = 1'b0;
  logic [3:0]         digito = '0;
  logic               enter_stb = 1'b0;
  logic               cancelar = 1'b0;
  logic [BAL_W-1:0]   balance_out;
  logic               balance_actualizar;
  logic               entregar_dinero;
  logic               fondos_insuficientes;
  logic [MONTO_W-1:0] monto;
  logic               ocupado;
  logic               fin;

  transaccion_cajero #(.BAL_W(BAL_W), .MONTO_W(MONTO_W), .MAX_DIG(9)) dut (
    .clk(clk), .reset(reset), .pin_ok(pin_ok), .balance_in(balance_in),
    .tipo_stb(tipo_stb), .tipo_trans(tipo_trans),
    .digito_stb(digito_stb), .digito(digito), .enter_stb(enter_stb),
    .cancelar(cancelar), .balance_out(balance_out),
    .balance_actualizar(balance_actualizar),
    .entregar_dinero(entregar_dinero),
    .fondos_insuficientes(fondos_insuficientes),
    .monto(monto), .ocupado(ocupado), .fin(fin)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;

  // Reference: phase 0 idle, 1 choosing type, 2 keying, 3 executing, 4 done.
  int               ph = 0;
  bit               m_retiro = 0;
  int               m_ndig = 0;
  logic [BAL_W-1:0] e_bal = '0;
  logic [63:0]      e_monto = '0;
  bit e_act = 0, e_ent = 0, e_ins = 0, e_fin = 0, e_ocup = 0;

  task automatic model();
    logic [BAL_W:0] s;
    e_act = 0; e_ent = 0; e_ins = 0; e_fin = 0;
    if (!reset) begin
      ph = 0; e_bal = '0; e_monto = '0; m_ndig = 0; m_retiro = 0;
    end else begin
      case (ph)
        0: if (pin_ok) begin
             e_bal = balance_in; e_monto = 0; m_ndig = 0; ph = 1;
           end
        1: if (cancelar) ph = 0;
           else if (tipo_stb) begin m_retiro = tipo_trans; ph = 2; end
        2: if (cancelar) ph = 0;
           else if (enter_stb) ph = 3;
           else if (digito_stb && digito < 10 && m_ndig < 9) begin
             e_monto = e_monto * 10 + 64'(digito);
             m_ndig++;
           end
        3: if (cancelar) ph = 0;
           else begin
             ph = 4; e_fin = 1;
             if (e_monto == 0) begin
             end else if (!m_retiro) begin
               s = (BAL_W+1)'(e_bal) + (BAL_W+1)'(e_monto);
               e_bal = (s > (BAL_W+1)'(MAXB)) ? MAXB : s[BAL_W-1:0];
               e_act = 1;
             end else if (e_monto > 64'(e_bal)) begin
               e_ins = 1;
             end else begin
               e_bal = e_bal - BAL_W'(e_monto);
               e_act = 1; e_ent = 1;
             end
           end
        default: ph = 0;
      endcase
    end
    e_ocup = (ph != 0);
  endtask

  task automatic compare();
    n_tests++;
    if (balance_out !== e_bal || monto !== MONTO_W'(e_monto) ||
        balance_actualizar !== e_act || entregar_dinero !== e_ent ||
        fondos_insuficientes !== e_ins || fin !== e_fin ||
        ocupado !== e_ocup) begin
      n_fail++;
      $display("FAIL cycle%0d: got bal=%0d monto=%0d act=%b ent=%b ins=%b fin=%b ocu=%b expected bal=%0d monto=%0d act=%b ent=%b ins=%b fin=%b ocu=%b",
        ncyc, balance_out, monto, balance_actualizar, entregar_dinero,
        fondos_insuficientes, fin, ocupado, e_bal, e_monto, e_act,
        e_ent, e_ins, e_fin, e_ocup);
    end
  endtask

  task automatic lit(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    @(negedge clk);
    ncyc++;
    compare();
    pin_ok = 0; tipo_stb = 0; digito_stb = 0;
    enter_stb = 0; cancelar = 0;
  endtask

  task automatic pin(input logic [BAL_W-1:0] b);
    pin_ok = 1; balance_in = b; cyc();
  endtask

  task automatic tipo(input bit t);
    tipo_stb = 1; tipo_trans = t; cyc();
  endtask

  task automatic dig(input logic [3:0] d);
    digito_stb = 1; digito = d; cyc();
  endtask

  task automatic enter();
    enter_stb = 1; cyc();
  endtask

  initial begin
    @(negedge clk);
    reset = 0;
    cyc(); cyc();
    lit("reset_bal", balance_out, 0);
    lit("reset_ocupado", 64'(ocupado), 0);
    reset = 1;
    cyc();

    // deposit 250 onto 1000
    pin(1000);
    lit("busy_after_pin", 64'(ocupado), 1);
    tipo(0); dig(2); dig(5); dig(0);
    lit("dep_monto", 64'(monto), 250);
    enter(); cyc();
    lit("dep_bal", balance_out, 1250);
    lit("dep_act_fin", {62'd0, balance_actualizar, fin}, 3);
    cyc();

    // withdraw exactly the balance
    pin(1000); tipo(1); dig(1); dig(0); dig(0); dig(0);
    enter(); cyc();
    lit("wd_eq_bal", balance_out, 0);
    lit("wd_eq_ent", 64'(entregar_dinero), 1);
    cyc();

    // withdraw one more than the balance
    pin(1000); tipo(1); dig(1); dig(0); dig(0); dig(1);
    enter(); cyc();
    lit("wd_ins", {61'd0, fondos_insuficientes, fin, entregar_dinero}, 6);
    lit("wd_ins_bal", balance_out, 1000);
    cyc();

    // digit limit and invalid digit
    pin(5); tipo(0);
    for (int i = 0; i < 12; i++) dig(9);
    lit("max_digits", 64'(monto), 999999999);
    dig(4'hA);
    lit("digit_A", 64'(monto), 999999999);
    enter(); cyc();
    lit("big_dep", balance_out, 1000000004);
    cyc();

    // cancel while keying, late pin_ok ignored
    pin(700); tipo(1);
    pin(123);
    lit("pin_ignored", balance_out, 700);
    dig(5); dig(0);
    cancelar = 1; cyc();
    lit("cancel_idle", 64'(ocupado), 0);
    cyc();
    lit("cancel_nofin", {62'd0, fin, entregar_dinero}, 0);
    lit("cancel_bal", balance_out, 700);

    // zero amount: only fin
    pin(300); tipo(0); enter(); cyc();
    lit("zero_fin_only", {60'd0, fin, balance_actualizar,
        entregar_dinero, fondos_insuficientes}, 8);
    cyc();

    // saturation
    pin(MAXB); tipo(0); dig(1); enter(); cyc();
    lit("saturate", balance_out, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc();

    // enter beats a simultaneous digit
    pin(50); tipo(0); dig(3);
    digito_stb = 1; digito = 7; enter();
    lit("enter_wins_monto", 64'(monto), 3);
    cyc();
    lit("enter_wins_bal", balance_out, 53);
    cyc();

    // reset during execution
    pin(80); tipo(1); dig(4); enter();
    reset = 0; cyc();
    lit("rst_exec", {balance_out[31:0], monto[15:0], 14'd0, fin, ocupado}, 0);
    reset = 1; cyc(); cyc();
    lit("rst_exec_nofin", 64'(fin), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
